mult_arb: RTL and testbench

Two-port round-robin arbiter and pipeline controller for the shared sign-magnitude multiplier. Two requesters present operand pairs over valid/ready handshakes. The block grants at most one pair per cycle and pushes it through a two-stage registered multiply pipeline. Each result returns tagged with the requester ID. It sits between the integrated multiplier datapath and the two client blocks that share it.

---
 rtl/mult_pkg.sv | 14 +
 rtl/mult_pipe.sv | 64 ++++++
 rtl/mult_arb.sv | 96 +++++++++
 tb/tb_mult_arb.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared widths and types for the round-robin multiplier arbiter
package mult_pkg;

   localparam int MULT_DW = 16;
   localparam int MULT_RW = 2*MULT_DW - 1;

   typedef logic req_id_t;

   typedef struct packed {
      logic                 sign;
      logic [MULT_DW-2:0]   mag;
   } sm_op_t;

endpackage

// File: rtl/mult_pipe.sv
// rtl/mult_pipe.sv - two-stage registered sign-magnitude multiply carrying a requester tag
module mult_pipe
   import mult_pkg::*;
#(
   parameter int DW = MULT_DW
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              valid_i,
   input  logic [DW-1:0]     a_i,
   input  logic [DW-1:0]     b_i,
   input  req_id_t           id_i,
   output logic              v1_o,
   output logic              valid_o,
   output req_id_t           id_o,
   output logic [2*DW-2:0]   data_o
);

   localparam int MW = DW - 1;

   logic [DW-1:0]     a_q, a_d, b_q, b_d;
   req_id_t           id1_q, id1_d, id2_q, id2_d;
   logic              v1_q, v2_q;
   logic              sign_q, sign_d;
   logic [2*MW-1:0]   mag_q, mag_d;

   // Registers only load on a live token so idle cycles leave the datapath quiet.
   always_comb begin
      a_d    = valid_i ? a_i  : a_q;
      b_d    = valid_i ? b_i  : b_q;
      id1_d  = valid_i ? id_i : id1_q;
      sign_d = v1_q ? (a_q[DW-1] ^ b_q[DW-1]) : sign_q;
      mag_d  = v1_q ? ({{MW{1'b0}}, a_q[MW-1:0]} * {{MW{1'b0}}, b_q[MW-1:0]}) : mag_q;
      id2_d  = v1_q ? id1_q : id2_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q    <= '0;
         b_q    <= '0;
         id1_q  <= 1'b0;
         v1_q   <= 1'b0;
         sign_q <= 1'b0;
         mag_q  <= '0;
         id2_q  <= 1'b0;
         v2_q   <= 1'b0;
      end else begin
         a_q    <= a_d;
         b_q    <= b_d;
         id1_q  <= id1_d;
         v1_q   <= valid_i;
         sign_q <= sign_d;
         mag_q  <= mag_d;
         id2_q  <= id2_d;
         v2_q   <= v1_q;
      end
   end

   assign v1_o    = v1_q;
   assign valid_o = v2_q;
   assign id_o    = id2_q;
   assign data_o  = {sign_q, mag_q};

endmodule

// File: rtl/mult_arb.sv
// rtl/mult_arb.sv - two-port round-robin arbiter in front of the shared multiply pipeline
// MULT_ARB_STATS_EN adds saturating per-requester grant counters.
module mult_arb
   import mult_pkg::*;
#(
   parameter int DW = MULT_DW
`ifdef MULT_ARB_STATS_EN
   , parameter int CNT_W = 16
`endif
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req0_valid,
   input  logic [DW-1:0]     req0_a,
   input  logic [DW-1:0]     req0_b,
   output logic              req0_ready,
   input  logic              req1_valid,
   input  logic [DW-1:0]     req1_a,
   input  logic [DW-1:0]     req1_b,
   output logic              req1_ready,
   output logic              res_valid,
   output logic              res_id,
   output logic [2*DW-2:0]   res_data,
   output logic              busy
`ifdef MULT_ARB_STATS_EN
   ,
   output logic [CNT_W-1:0]  grant_cnt0,
   output logic [CNT_W-1:0]  grant_cnt1
`endif
);

   logic       prio_q, prio_d;
   logic       grant0, grant1;
   logic       v1;
   req_id_t    out_id;

   always_comb begin
      grant0 = req0_valid & (~req1_valid | ~prio_q);
      grant1 = req1_valid & (~req0_valid |  prio_q);
      prio_d = prio_q;
      if (grant0)      prio_d = 1'b1;
      else if (grant1) prio_d = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) prio_q <= 1'b0;
      else        prio_q <= prio_d;
   end

   assign req0_ready = grant0;
   assign req1_ready = grant1;

   mult_pipe #(.DW(DW)) u_pipe (
      .clk     (clk),
      .rst_n   (rst_n),
      .valid_i (grant0 | grant1),
      .a_i     (grant1 ? req1_a : req0_a),
      .b_i     (grant1 ? req1_b : req0_b),
      .id_i    (grant1),
      .v1_o    (v1),
      .valid_o (res_valid),
      .id_o    (out_id),
      .data_o  (res_data)
   );

   assign res_id = out_id;
   assign busy   = v1 | res_valid;

`ifdef MULT_ARB_STATS_EN
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [CNT_W-1:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;

   // Counters stick at all-ones rather than wrapping.
   always_comb begin
      cnt0_d = cnt0_q;
      cnt1_d = cnt1_q;
      if (grant0 && (cnt0_q != '1)) cnt0_d = cnt0_q + CNT_ONE;
      if (grant1 && (cnt1_q != '1)) cnt1_d = cnt1_q + CNT_ONE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt0_q <= '0;
         cnt1_q <= '0;
      end else begin
         cnt0_q <= cnt0_d;
         cnt1_q <= cnt1_d;
      end
   end

   assign grant_cnt0 = cnt0_q;
   assign grant_cnt1 = cnt1_q;
`endif

endmodule

// File: tb/tb_mult_arb.sv
// tb/tb_mult_arb.sv - scoreboard bench for mult_arb (build with MULT_ARB_STATS_EN for counter checks)
module tb_mult_arb;
   import mult_pkg::*;

   localparam int DW = MULT_DW;
   localparam int RW = MULT_RW;

   typedef struct {
      logic           id;
      logic [RW-1:0]  data;
      int             cyc;
   } exp_t;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            req0_valid, req1_valid;
   logic [DW-1:0]   req0_a, req0_b, req1_a, req1_b;
   logic            req0_ready, req1_ready;
   logic            res_valid, res_id, busy;
   logic [RW-1:0]   res_data;
`ifdef MULT_ARB_STATS_EN
   localparam int CNT_W = 4;
   logic [CNT_W-1:0] grant_cnt0, grant_cnt1;
`endif

   int             n_tests = 0;
   int             n_fail  = 0;
   int             cyc     = 0;
   int             res_seen = 0;
   exp_t           sb_q[$];
   logic           grant_q[$];
   logic [RW-1:0]  res_log[$];

   mult_arb #(
      .DW(DW)
`ifdef MULT_ARB_STATS_EN
      , .CNT_W(CNT_W)
`endif
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req0_valid (req0_valid),
      .req0_a     (req0_a),
      .req0_b     (req0_b),
      .req0_ready (req0_ready),
      .req1_valid (req1_valid),
      .req1_a     (req1_a),
      .req1_b     (req1_b),
      .req1_ready (req1_ready),
      .res_valid  (res_valid),
      .res_id     (res_id),
      .res_data   (res_data),
      .busy       (busy)
`ifdef MULT_ARB_STATS_EN
      ,
      .grant_cnt0 (grant_cnt0),
      .grant_cnt1 (grant_cnt1)
`endif
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [RW-1:0] sm_mul(input logic [DW-1:0] a, input logic [DW-1:0] b);
      logic [RW-2:0] m;
      m = (RW-1)'(a[DW-2:0]) * (RW-1)'(b[DW-2:0]);
      return {a[DW-1] ^ b[DW-1], m};
   endfunction

   function automatic logic [DW-1:0] rnd_op();
      sm_op_t op;
      op.sign = 1'($urandom);
      op.mag  = (DW-1)'($urandom);
      return op;
   endfunction

   // Scoreboard: results are checked before this cycle's grants are pushed.
   always @(negedge clk) begin
      if (!rst_n) begin
         sb_q.delete();
      end else begin
         if (res_valid) begin
            res_seen++;
            res_log.push_back(res_data);
            if (sb_q.size() == 0) begin
               check_eq("unexpected_res", 64'd1, 64'd0);
            end else begin
               exp_t e;
               e = sb_q.pop_front();
               check_eq("res_id", 64'(res_id), 64'(e.id));
               check_eq("res_data", 64'(res_data), 64'(e.data));
               check_eq("res_latency", 64'(cyc), 64'(e.cyc));
            end
         end
         if (req0_valid && req1_valid)
            check_eq("one_grant", 64'(req0_ready & req1_ready), 64'd0);
         if (req0_valid && req0_ready) begin
            sb_q.push_back('{id: 1'b0, data: sm_mul(req0_a, req0_b), cyc: cyc + 2});
            grant_q.push_back(1'b0);
         end
         if (req1_valid && req1_ready) begin
            sb_q.push_back('{id: 1'b1, data: sm_mul(req1_a, req1_b), cyc: cyc + 2});
            grant_q.push_back(1'b1);
         end
      end
   end

   task automatic drive(input logic v0, input logic [DW-1:0] a0, input logic [DW-1:0] b0,
                        input logic v1, input logic [DW-1:0] a1, input logic [DW-1:0] b1);
      req0_valid = v0; req0_a = a0; req0_b = b0;
      req1_valid = v1; req1_a = a1; req1_b = b1;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, '0, '0, 1'b0, '0, '0);
   endtask

   task automatic do_reset();
      req0_valid = 1'b0; req1_valid = 1'b0;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      int base;
      rst_n = 1'b0;
      req0_valid = 1'b0; req0_a = '0; req0_b = '0;
      req1_valid = 1'b0; req1_a = '0; req1_b = '0;
      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_res_valid", 64'(res_valid), 64'd0);
      check_eq("rst_res_id", 64'(res_id), 64'd0);
      check_eq("rst_res_data", 64'(res_data), 64'd0);
      check_eq("rst_busy", 64'(busy), 64'd0);
      check_eq("rst_ready", 64'({req0_ready, req1_ready}), 64'd0);
`ifdef MULT_ARB_STATS_EN
      check_eq("rst_cnt", 64'({grant_cnt0, grant_cnt1}), 64'd0);
`endif
      rst_n = 1'b1;
      idle(2);
      check_eq("idle_busy", 64'(busy), 64'd0);

      // Single request from requester 0
      res_log.delete();
      drive(1'b1, 16'h0003, 16'h8005, 1'b0, '0, '0);
      check_eq("single_busy", 64'(busy), 64'd1);
      idle(4);
      check_eq("single_count", 64'(res_log.size()), 64'd1);
      if (res_log.size() > 0) check_eq("single_value", 64'(res_log[0]), 64'h4000000F);
      check_eq("single_drain_busy", 64'(busy), 64'd0);

      // Magnitude extremes and negative zero
      res_log.delete();
      drive(1'b1, 16'h7FFF, 16'h7FFF, 1'b0, '0, '0);
      drive(1'b1, 16'h8000, 16'h0001, 1'b0, '0, '0);
      idle(4);
      check_eq("edge_count", 64'(res_log.size()), 64'd2);
      if (res_log.size() > 1) begin
         check_eq("max_mag", 64'(res_log[0]), 64'h3FFF0001);
         check_eq("neg_zero", 64'(res_log[1]), 64'h40000000);
      end

      // Continuous contention alternates starting at requester 0
      do_reset();
      grant_q.delete();
      for (int i = 0; i < 6; i++) drive(1'b1, rnd_op(), rnd_op(), 1'b1, rnd_op(), rnd_op());
      idle(4);
      check_eq("alt_count", 64'(grant_q.size()), 64'd6);
      for (int i = 0; i < 6 && i < grant_q.size(); i++)
         check_eq($sformatf("alt_grant%0d", i), 64'(grant_q[i]), 64'(i % 2));
      check_eq("alt_drain", 64'(sb_q.size()), 64'd0);

      // Requester 1 alone, then contention goes to requester 0
      do_reset();
      grant_q.delete();
      for (int i = 0; i < 3; i++) drive(1'b0, '0, '0, 1'b1, rnd_op(), rnd_op());
      drive(1'b1, rnd_op(), rnd_op(), 1'b1, rnd_op(), rnd_op());
      idle(4);
      check_eq("r1_count", 64'(grant_q.size()), 64'd4);
      if (grant_q.size() == 4) begin
         check_eq("r1_solo", 64'({grant_q[0], grant_q[1], grant_q[2]}), 64'b111);
         check_eq("r1_contend", 64'(grant_q[3]), 64'd0);
      end

      // Reset with two results in flight discards them
      drive(1'b1, rnd_op(), rnd_op(), 1'b0, '0, '0);
      drive(1'b0, '0, '0, 1'b1, rnd_op(), rnd_op());
      req1_valid = 1'b0;
      check_eq("inflight_busy", 64'(busy), 64'd1);
      check_eq("inflight_valid", 64'(res_valid), 64'd1);
      rst_n = 1'b0;
      base = res_seen;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      idle(5);
      check_eq("flush_results", 64'(res_seen - base), 64'd0);
      check_eq("flush_busy", 64'(busy), 64'd0);

`ifdef MULT_ARB_STATS_EN
      do_reset();
      for (int i = 0; i < 10; i++) drive(1'b1, rnd_op(), rnd_op(), 1'b0, '0, '0);
      check_eq("cnt0_mid", 64'(grant_cnt0), 64'd10);
      for (int i = 0; i < 10; i++) drive(1'b1, rnd_op(), rnd_op(), 1'b0, '0, '0);
      check_eq("cnt0_sat", 64'(grant_cnt0), 64'hF);
      drive(1'b0, '0, '0, 1'b1, rnd_op(), rnd_op());
      check_eq("cnt1", 64'(grant_cnt1), 64'd1);
      idle(4);
`endif

      check_eq("final_drain", 64'(sb_q.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
